inv_key_sched: RTL
==================

Name: inv_key_sched

Overview:
Iterative AES-128 round-key generator for the decryption datapath. It accepts the cipher key, expands it forward internally to round key NR, then streams round keys NR down to 0 with a valid/ready handshake. Each step toward round 0 is computed by the inverse key-expansion step. It feeds the inverse-cipher round pipeline, which needs the last round key first.

Parameters:
NR, 10, number of AES rounds. Legal range is 1..10, bounded by the Rcon table.

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  load key_in and begin a run; sampled only while ready=1
key_in  input  128  cipher key (round-0 key); word 0 is in [127:96], word 3 is in [31:0]
ready  output  1  high when idle and able to accept start
out_valid  output  1  out_key/out_round hold a valid round key
out_ready  input  1  consumer accepts the current key
out_key  output  128  current round key, same word/byte ordering as key_in
out_round  output  4  index of the round key on out_key (NR..0)
done  output  1  one-cycle pulse after round key 0 is accepted

Behaviour:
- Reset values, also applied on rst asserted mid-run: state=IDLE, ready=1, out_valid=0, out_key=0, out_round=0, done=0, internal counter=0. Any run in progress is abandoned with no done pulse.
- Word ordering: w0=[127:96], w1=[95:64], w2=[63:32], w3=[31:0]. Rcon(i) is placed in byte [31:24] of the Rcon word; the rest of that word is zero.
- RotWord(w) = {w[23:0], w[31:24]}. SubWord applies the AES S-box per byte, indexed by {hi nibble, lo nibble}.
- g(w,i) = SubWord(RotWord(w)) ^ {Rcon(i), 24'h0}.
- Forward step for round i: n0=w0^g(w3,i), n1=n0^w1, n2=n1^w2, n3=n2^w3.
- Inverse step from round i to round i-1: p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^g(p3,i).
- FSM states:
  - IDLE: ready=1. On start, key_reg<=key_in, cnt<=1, go to EXPAND. start while not IDLE is ignored.
  - EXPAND: each cycle, key_reg<=fwd(key_reg,cnt) and cnt<=cnt+1. On the cycle cnt==NR, go to EMIT with rnd<=NR. Takes exactly NR cycles.
  - EMIT: out_valid=1, out_key=key_reg, out_round=rnd. Outputs are stable while out_ready=0.
    - On out_valid&&out_ready with rnd>0: key_reg<=inv(key_reg,rnd), rnd<=rnd-1, stay in EMIT. The next key is valid on the following cycle, so one key per cycle is possible with out_ready held high.
    - On accept with rnd==0: go to IDLE, out_valid<=0, done<=1 for one cycle, ready=1 in the same cycle as done.
- Latency: start edge to first out_valid is NR cycles, so 10 by default. A full run with out_ready held high is 1 + NR + (NR+1) cycles from start to done.
- The four S-box instances are shared between the forward and inverse paths through a state-driven mux on the input word: w3 in EXPAND, w3^w2 in EMIT. The S-box stays combinational; all outputs are registered or decoded directly from the state.
- start and out_ready are sampled only at clock edges; combinational start->ready paths are not allowed.

Decomposition:
- Shared package aes_pkg holds:
  - the Rcon function/constant table for 1..10 (01,02,04,08,10,20,40,80,1b,36)
  - the FSM state encoding: IDLE, EXPAND, EMIT
  - the RotWord helper
- The existing sbox module is reused for 4 instances.
- One natural sub-module: inv_key_step. It is the combinational inverse step, takes key and rcon, and internally uses the 4 sboxes. It can be checked standalone against the forward step.

Test Plan:
- Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c and out_ready=1: the first out_valid comes 10 cycles after start with out_key=d014f9a8c9ee2589e13f0cc8b6630ca6, out_round=10. The next cycle gives ac7766f319fadc2128d12941575c006e with round 9. The out_round=1 key is a0fafe1788542cb123a339392a6c7605, the out_round=0 key equals key_in, and done pulses for exactly 1 cycle.
- Same key with out_ready toggled pseudo-randomly: out_key and out_round stay stable while stalled, the sequence of 11 keys is identical to the first test, and no key is skipped or duplicated.
- start asserted during EXPAND and during EMIT with a different key_in: it is ignored, the output sequence is unchanged, and ready=0 throughout.
- rst asserted while in EMIT at round 5: out_valid, out_key, out_round and done all drop to 0 immediately (asynchronously) and ready=1. The next start with key_in=000102030405060708090a0b0c0d0e0f gives round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back runs: start asserted the same cycle done pulses and ready=1 is accepted, and the second run's first key appears 10 cycles later.
- Self-check with randomized key_in values: each emitted key k(i) satisfies fwd(k(i-1),i)==k(i) against a reference model, and round 0 equals key_in.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: FSM encoding, Rcon table and RotWord.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_e;

  // Rcon for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/inv_key_step.sv
// Combinational AES-128 key-expansion step, forward (fwd_i=1) or inverse (fwd_i=0).
// The four S-boxes are shared: their input word is w3 going forward, w3^w2 going back.
module inv_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  input  logic         fwd_i,
  output logic [127:0] key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p3, sub_in, rot, sub_out, g;

  assign {w0, w1, w2, w3} = key_i;
  assign p3     = w3 ^ w2;
  assign sub_in = fwd_i ? w3 : p3;
  assign rot    = rot_word(sub_in);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      sbox u_sbox (
        .in_i  (rot[gi*8 +: 8]),
        .out_o (sub_out[gi*8 +: 8])
      );
    end
  endgenerate

  assign g = sub_out ^ {rcon_i, 24'h0};

  always_comb begin
    logic [31:0] n0, n1, n2, n3;
    n0 = w0 ^ g;
    n1 = n0 ^ w1;
    n2 = n1 ^ w2;
    n3 = n2 ^ w3;
    if (fwd_i) begin
      key_o = {n0, n1, n2, n3};
    end else begin
      key_o = {w0 ^ g, w1 ^ w0, w2 ^ w1, p3};
    end
  end

endmodule

// File: rtl/sbox.sv
// Combinational AES forward S-box, indexed by {hi nibble, lo nibble}.
module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX_TABLE [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX_TABLE[in_i];

endmodule

// File: rtl/inv_key_sched.sv
// Iterative AES-128 decryption key scheduler: expands forward to round NR,
// then streams round keys NR..0 over a valid/ready handshake.
module inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10  // 1..10, limited by the Rcon table
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         done
);

  localparam logic [3:0] NR_W = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic         fwd_sel;
  logic [7:0]   rcon_sel;
  logic [127:0] step_key;

  assign fwd_sel  = (state_q != EMIT);
  assign rcon_sel = rcon(fwd_sel ? cnt_q : rnd_q);

  inv_key_step u_step (
    .key_i  (key_q),
    .rcon_i (rcon_sel),
    .fwd_i  (fwd_sel),
    .key_o  (step_key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        key_d = step_key;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == NR_W) begin
          state_d = EMIT;
          rnd_d   = NR_W;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (rnd_q != 4'd0) begin
            key_d = step_key;
            rnd_d = rnd_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset clears them at once.
  assign ready     = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_key   = out_valid ? key_q : '0;
  assign out_round = out_valid ? rnd_q : '0;
  assign done      = done_q;

endmodule
